// File: rtl/watchdog_reset_sequencer.sv
// Turns a watchdog trip pulse into a fixed-width core reset, ignores trips during
// a post-release holdoff window, and keeps trip diagnostics for software.
module watchdog_reset_sequencer #(
  parameter int RST_HOLD_CYCLES = 8,
  parameter int HOLDOFF_CYCLES  = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 watchdog_rst,
  input  logic [31:0]          present_pc,
  input  logic                 cause_clr,
  output logic                 core_rst_n,
  output logic                 wdt_active,
  output logic [31:0]          last_trip_pc,
  output logic [CNT_WIDTH-1:0] trip_count,
  output logic                 wdt_cause
);

  localparam int MAX_CYCLES = (RST_HOLD_CYCLES > HOLDOFF_CYCLES) ? RST_HOLD_CYCLES : HOLDOFF_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_INIT = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] HOFF_INIT = TW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      core_rst_n   <= 1'b0;
      wdt_active   <= 1'b0;
      last_trip_pc <= '0;
      trip_count   <= '0;
      wdt_cause    <= 1'b0;
    end else begin
      // An accepted trip below re-sets the flag, so the set wins over a clear.
      if (cause_clr)
        wdt_cause <= 1'b0;

      case (state)
        IDLE: begin
          // First cycle out of system reset only releases the core.
          if (!core_rst_n) begin
            core_rst_n <= 1'b1;
          end else if (watchdog_rst) begin
            state        <= ASSERT;
            timer        <= HOLD_INIT;
            core_rst_n   <= 1'b0;
            wdt_active   <= 1'b1;
            last_trip_pc <= present_pc;
            wdt_cause    <= 1'b1;
            if (trip_count != '1)
              trip_count <= trip_count + 1'b1;
          end
        end

        ASSERT: begin
          if (timer == '0) begin
            core_rst_n <= 1'b1;
            if (HOLDOFF_CYCLES > 0) begin
              state <= HOLDOFF;
              timer <= HOFF_INIT;
            end else begin
              state      <= IDLE;
              wdt_active <= 1'b0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        HOLDOFF: begin
          if (timer == '0) begin
            state      <= IDLE;
            wdt_active <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          wdt_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watchdog_reset_sequencer.sv
// Directed bench for watchdog_reset_sequencer: default instance plus a 2-bit counter
// instance sharing the same stimulus to exercise trip_count saturation.
module tb_watchdog_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        watchdog_rst;
  logic [31:0] present_pc;
  logic        cause_clr;

  logic        core_rst_n, wdt_active, wdt_cause;
  logic [31:0] last_trip_pc;
  logic [7:0]  trip_count;

  logic        core_rst_n2, wdt_active2, wdt_cause2;
  logic [31:0] last_trip_pc2;
  logic [1:0]  trip_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  watchdog_reset_sequencer dut (
    .clk(clk), .rst_n(rst_n), .watchdog_rst(watchdog_rst), .present_pc(present_pc),
    .cause_clr(cause_clr), .core_rst_n(core_rst_n), .wdt_active(wdt_active),
    .last_trip_pc(last_trip_pc), .trip_count(trip_count), .wdt_cause(wdt_cause)
  );

  watchdog_reset_sequencer #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .watchdog_rst(watchdog_rst), .present_pc(present_pc),
    .cause_clr(cause_clr), .core_rst_n(core_rst_n2), .wdt_active(wdt_active2),
    .last_trip_pc(last_trip_pc2), .trip_count(trip_count2), .wdt_cause(wdt_cause2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (wdt_active && n < 200) begin
      tick();
      n++;
    end
    if (wdt_active) begin
      checks++;
      failures++;
      $error("FAIL wait_idle_timeout observed=1 expected=0");
    end
  endtask

  initial begin
    int n, low, act;
    bit seen_high;

    rst_n = 1'b0; watchdog_rst = 1'b1; present_pc = 32'h0; cause_clr = 1'b0;

    // 1: reset dominates a held trip request
    repeat (3) tick();
    chk("rst_core_rst_n", 32'(core_rst_n), 0);
    chk("rst_wdt_active", 32'(wdt_active), 0);
    chk("rst_trip_count", 32'(trip_count), 0);
    chk("rst_wdt_cause",  32'(wdt_cause), 0);
    chk("rst_last_pc",    last_trip_pc, 0);
    rst_n = 1'b1;
    tick();
    chk("release_core_rst_n", 32'(core_rst_n), 1);
    chk("release_no_trip_active", 32'(wdt_active), 0);
    chk("release_no_trip_count", 32'(trip_count), 0);
    watchdog_rst = 1'b0;
    tick();

    // 2 + 3: one trip, with dropped pulses in ASSERT and HOLDOFF
    present_pc = 32'h0000_0040; watchdog_rst = 1'b1;
    tick();
    chk("trip1_core_rst_n", 32'(core_rst_n), 0);
    chk("trip1_active", 32'(wdt_active), 1);
    chk("trip1_pc", last_trip_pc, 32'h40);
    chk("trip1_count", 32'(trip_count), 1);
    chk("trip1_cause", 32'(wdt_cause), 1);
    low = 1; act = 1;
    for (int c = 1; c < 100 && wdt_active; c++) begin
      watchdog_rst = (c == 3 || c == 18);
      present_pc   = (c == 3 || c == 18) ? 32'hDEAD_BEEF : 32'h40;
      tick();
      if (!core_rst_n) low++;
      if (wdt_active)  act++;
    end
    watchdog_rst = 1'b0;
    chk("trip1_low_cycles", 32'(low), 8);
    chk("trip1_active_cycles", 32'(act), 24);
    chk("dropped_count", 32'(trip_count), 1);
    chk("dropped_pc", last_trip_pc, 32'h40);

    present_pc = 32'h0000_0100; watchdog_rst = 1'b1;
    tick();
    watchdog_rst = 1'b0;
    chk("first_idle_trip_count", 32'(trip_count), 2);
    chk("first_idle_trip_pc", last_trip_pc, 32'h100);
    chk("first_idle_trip_core", 32'(core_rst_n), 0);
    wait_idle(n);
    chk("trip2_active_ticks", 32'(n), 24);

    // 5: set wins over clear on an accepted-trip edge, clear alone works
    cause_clr = 1'b1; watchdog_rst = 1'b1; present_pc = 32'h200;
    tick();
    watchdog_rst = 1'b0; cause_clr = 1'b0;
    chk("cause_set_wins", 32'(wdt_cause), 1);
    wait_idle(n);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("cause_cleared", 32'(wdt_cause), 0);
    chk("cause_clear_no_trip", 32'(trip_count), 3);

    // level-high request re-trips every 8+16+1 cycles
    watchdog_rst = 1'b1;
    tick();
    chk("level_first_trip", 32'(core_rst_n), 0);
    n = 0; seen_high = 0;
    do begin
      tick();
      n++;
      if (core_rst_n) seen_high = 1;
    end while (!(seen_high && !core_rst_n) && n < 100);
    watchdog_rst = 1'b0;
    chk("level_retrip_period", 32'(n), 25);
    chk("level_trip_count", 32'(trip_count), 5);
    wait_idle(n);

    // 6: system reset in the middle of ASSERT
    watchdog_rst = 1'b1; present_pc = 32'h300;
    tick();
    watchdog_rst = 1'b0;
    repeat (3) tick();
    chk("mid_assert_core", 32'(core_rst_n), 0);
    rst_n = 1'b0;
    tick();
    chk("midrst_core", 32'(core_rst_n), 0);
    chk("midrst_active", 32'(wdt_active), 0);
    chk("midrst_count", 32'(trip_count), 0);
    chk("midrst_pc", last_trip_pc, 0);
    chk("midrst_cause", 32'(wdt_cause), 0);
    tick();
    chk("midrst_core_held", 32'(core_rst_n), 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_release", 32'(core_rst_n), 1);

    // 4: saturation of a 2-bit trip counter
    for (int k = 1; k <= 5; k++) begin
      watchdog_rst = 1'b1; present_pc = 32'h1000 + 32'(k);
      tick();
      watchdog_rst = 1'b0;
      chk("sat_count_w8", 32'(trip_count), 32'(k));
      chk("sat_count_w2", 32'(trip_count2), (k < 3) ? 32'(k) : 32'd3);
      wait_idle(n);
    end
    chk("sat_last_pc_w2", last_trip_pc2, 32'h1005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
